pipe_scheduler: RTL

Game-level controller for the bank of pipe position counters in SpacyBird. It owns N_PIPES pipe slots and decides when each slot spawns at the right screen edge, with a random gap height. It retires slots when they leave the screen, counts score as pipes pass the bird, and issues speed-increment pulses. It sits between the game FSM inputs (start, collision) and the per-pipe position counters, and drives their reset, move and speed-increment inputs.

---
 rtl/pipe_scheduler.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_scheduler.sv
// pipe_scheduler: game-level controller for the SpacyBird pipe slots.
// Spawns pipes at the right edge with a pseudo-random gap row, retires them
// when they leave the screen, counts score as pipes pass the bird and issues
// periodic speed-increment pulses to the pipe position counters.
//
// Ports:
//   iClk, iRst    clock, synchronous active-high reset
//   iStart        start / restart request (IDLE or HALT -> CLEAR)
//   iCollision    bird collision, ends the game (RUN -> HALT)
//   iPipeOut      per-slot "pipe has left the screen" flags
//   iPosBus       per-slot positions, slot i at [i*P_SIZE +: P_SIZE]
//   oPipeRst      one-cycle pulse resetting all pipe counters
//   oPosRst       per-slot spawn pulse (counter loads START_POS)
//   oPosMove      movement enable for all counters
//   oSpeedInc     one-cycle speed-increment pulse
//   oActive       per-slot on-screen flag
//   oGapBus       per-slot latched gap-top row, slot i at [i*GAP_W +: GAP_W]
//   oScore        score, saturating at 999
//   oGameOver     high while halted after a collision
module pipe_scheduler #(
    parameter int          N_PIPES    = 3,
    parameter int          H_TOT      = 800,
    parameter int          P_SIZE     = $clog2(H_TOT),
    parameter int          START_POS  = 150,
    parameter int          SPACING    = 60,
    parameter int          BIRD_X     = 40,
    parameter int          GAP_MIN    = 100,
    parameter int          GAP_W      = 10,
    parameter int          SCORE_STEP = 5,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic                       iStart,
    input  logic                       iCollision,
    input  logic [N_PIPES-1:0]         iPipeOut,
    input  logic [N_PIPES*P_SIZE-1:0]  iPosBus,
    output logic                       oPipeRst,
    output logic [N_PIPES-1:0]         oPosRst,
    output logic                       oPosMove,
    output logic                       oSpeedInc,
    output logic [N_PIPES-1:0]         oActive,
    output logic [N_PIPES*GAP_W-1:0]   oGapBus,
    output logic [9:0]                 oScore,
    output logic                       oGameOver
);

    localparam int IDX_W  = (N_PIPES > 1) ? $clog2(N_PIPES) : 1;
    localparam int STEP_W = (SCORE_STEP > 1) ? $clog2(SCORE_STEP) : 1;
    localparam logic [N_PIPES-1:0] ONE_N = {{(N_PIPES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    // 16-bit Fibonacci LFSR step, taps 16/14/13/11
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    state_t             state_r;
    logic               pipe_rst_r;
    logic               pos_move_r;
    logic               speed_inc_r;
    logic               wrap_pend_r;
    logic               game_over_r;
    logic [N_PIPES-1:0] pos_rst_r;
    logic [N_PIPES-1:0] active_r;
    logic [N_PIPES-1:0] scored_r;
    logic [GAP_W-1:0]   gap_r [N_PIPES];
    logic [9:0]         score_r;
    logic [STEP_W-1:0]  step_r;
    logic [IDX_W-1:0]   last_r;
    logic [15:0]        lfsr_r;

    logic [P_SIZE-1:0]  pos_s [N_PIPES];
    logic [P_SIZE-1:0]  last_pos_s;
    logic [N_PIPES-1:0] retire_s;
    logic [N_PIPES-1:0] free_s;
    logic [N_PIPES-1:0] spawn_oh_s;
    logic [N_PIPES-1:0] spawn_mask_s;
    logic [N_PIPES-1:0] cand_s;
    logic [N_PIPES-1:0] score_oh_s;
    logic [IDX_W-1:0]   spawn_idx_s;
    logic               spawn_s;
    logic               score_ok_s;
    logic               wrap_s;
    logic [GAP_W-1:0]   gap_new_s;

    // Spawn / retire / score decisions for the current cycle
    always_comb begin
        free_s      = ~active_r;
        // lowest set bit of the free mask picks the spawn slot
        spawn_oh_s  = free_s & (~free_s + ONE_N);
        retire_s    = active_r & iPipeOut & ~pos_rst_r;
        cand_s      = {N_PIPES{1'b0}};
        last_pos_s  = {P_SIZE{1'b0}};
        spawn_idx_s = {IDX_W{1'b0}};
        for (int i = 0; i < N_PIPES; i++) begin
            pos_s[i]    = iPosBus[i*P_SIZE +: P_SIZE];
            // a slot pulsing oPosRst still shows its previous position
            cand_s[i]   = active_r[i] & ~scored_r[i] & ~pos_rst_r[i]
                          & (pos_s[i] < P_SIZE'(BIRD_X));
            last_pos_s  = (last_r == IDX_W'(i)) ? pos_s[i] : last_pos_s;
            spawn_idx_s = spawn_idx_s | (spawn_oh_s[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
        score_oh_s   = cand_s & (~cand_s + ONE_N);
        // a just-retired slot is still marked active here, so it cannot be
        // re-spawned before the following cycle
        spawn_s      = (pos_rst_r == {N_PIPES{1'b0}})
                       && ((active_r == {N_PIPES{1'b0}})
                           || ((last_pos_s <= P_SIZE'(START_POS - SPACING))
                               && (free_s != {N_PIPES{1'b0}})));
        spawn_mask_s = spawn_s ? spawn_oh_s : {N_PIPES{1'b0}};
        score_ok_s   = (score_oh_s != {N_PIPES{1'b0}}) && (score_r != 10'd999);
        wrap_s       = (step_r == STEP_W'(SCORE_STEP - 1));
        gap_new_s    = GAP_W'(GAP_MIN) + GAP_W'(lfsr_r[6:0]);
    end

    // Game FSM, slot bookkeeping, score and LFSR
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_r     <= S_IDLE;
            pipe_rst_r  <= 1'b0;
            pos_move_r  <= 1'b0;
            speed_inc_r <= 1'b0;
            wrap_pend_r <= 1'b0;
            game_over_r <= 1'b0;
            pos_rst_r   <= {N_PIPES{1'b0}};
            active_r    <= {N_PIPES{1'b0}};
            scored_r    <= {N_PIPES{1'b0}};
            score_r     <= 10'd0;
            step_r      <= {STEP_W{1'b0}};
            last_r      <= {IDX_W{1'b0}};
            lfsr_r      <= LFSR_SEED;
            for (int i = 0; i < N_PIPES; i++) begin
                gap_r[i] <= {GAP_W{1'b0}};
            end
        end else begin
            lfsr_r      <= lfsr_step(lfsr_r);
            pipe_rst_r  <= 1'b0;
            pos_rst_r   <= {N_PIPES{1'b0}};
            // speed pulse trails the wrapping point by one cycle
            speed_inc_r <= wrap_pend_r;
            wrap_pend_r <= 1'b0;
            case (state_r)
                S_IDLE, S_HALT: begin
                    if (iStart) begin
                        state_r     <= S_CLEAR;
                        pipe_rst_r  <= 1'b1;
                        pos_move_r  <= 1'b0;
                        game_over_r <= 1'b0;
                        speed_inc_r <= 1'b0;
                        active_r    <= {N_PIPES{1'b0}};
                        scored_r    <= {N_PIPES{1'b0}};
                        score_r     <= 10'd0;
                        step_r      <= {STEP_W{1'b0}};
                        last_r      <= {IDX_W{1'b0}};
                        for (int i = 0; i < N_PIPES; i++) begin
                            gap_r[i] <= {GAP_W{1'b0}};
                        end
                    end
                end
                S_CLEAR: begin
                    state_r    <= S_RUN;
                    pos_move_r <= 1'b1;
                end
                S_RUN: begin
                    if (iCollision) begin
                        state_r     <= S_HALT;
                        pos_move_r  <= 1'b0;
                        game_over_r <= 1'b1;
                    end else begin
                        active_r  <= (active_r & ~retire_s) | spawn_mask_s;
                        scored_r  <= (scored_r | score_oh_s) & ~spawn_mask_s;
                        pos_rst_r <= spawn_mask_s;
                        if (spawn_s) begin
                            last_r <= spawn_idx_s;
                        end
                        for (int i = 0; i < N_PIPES; i++) begin
                            if (spawn_mask_s[i]) begin
                                gap_r[i] <= gap_new_s;
                            end
                        end
                        if (score_ok_s) begin
                            score_r <= score_r + 10'd1;
                            if (wrap_s) begin
                                step_r      <= {STEP_W{1'b0}};
                                wrap_pend_r <= 1'b1;
                            end else begin
                                step_r <= step_r + STEP_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Flatten the gap registers onto the output bus
    always_comb begin
        oGapBus = {(N_PIPES*GAP_W){1'b0}};
        for (int i = 0; i < N_PIPES; i++) begin
            oGapBus[i*GAP_W +: GAP_W] = gap_r[i];
        end
    end

    assign oPipeRst  = pipe_rst_r;
    assign oPosRst   = pos_rst_r;
    assign oPosMove  = pos_move_r;
    assign oSpeedInc = speed_inc_r;
    assign oActive   = active_r;
    assign oScore    = score_r;
    assign oGameOver = game_over_r;

endmodule
